// File: rtl/interrupt_controller_pkg.sv
// Shared types and register addresses for the peripheral interrupt controller.
package interrupt_controller_pkg;

    // Width of the request vector handed to the microcode sequencer.
    localparam int unsigned NUM_VECTORS = 15;

    // Vector index doubles as priority: the sequencer services the highest set bit.
    typedef enum logic [3:0] {
        IRQ_CLOCK      = 4'd1,
        IRQ_STOPWATCH  = 4'd2,
        IRQ_K1         = 4'd3,
        IRQ_K0         = 4'd4,
        IRQ_SERIAL     = 4'd5,
        IRQ_PROG_TIMER = 4'd6
    } irq_vector_e;

    // Factor flag registers (read-to-clear).
    localparam logic [3:0] ADDR_IT    = 4'h0;
    localparam logic [3:0] ADDR_ISW   = 4'h1;
    localparam logic [3:0] ADDR_IPT   = 4'h2;
    localparam logic [3:0] ADDR_ISIO  = 4'h3;
    localparam logic [3:0] ADDR_IK    = 4'h4;
    // Unused: 4'h5 .. 4'h7
    // Mask and polarity registers (read/write).
    localparam logic [3:0] ADDR_EIT   = 4'h8;
    localparam logic [3:0] ADDR_EISW  = 4'h9;
    localparam logic [3:0] ADDR_EIPT  = 4'hA;
    localparam logic [3:0] ADDR_EISIO = 4'hB;
    localparam logic [3:0] ADDR_EIK0  = 4'hC;
    localparam logic [3:0] ADDR_EIK1  = 4'hD;
    localparam logic [3:0] ADDR_KCP0  = 4'hE;
    localparam logic [3:0] ADDR_KCP1  = 4'hF;

endpackage

// File: rtl/interrupt_controller_if.sv
// Nibble-wide register bus between the CPU I/O space and the interrupt controller.
interface interrupt_controller_if;

    logic [3:0] addr;
    logic       wr_en;
    logic [3:0] wr_data;
    logic       rd_en;
    logic [3:0] rd_data;

    modport master (
        output addr,
        output wr_en,
        output wr_data,
        output rd_en,
        input  rd_data
    );

    modport slave (
        input  addr,
        input  wr_en,
        input  wr_data,
        input  rd_en,
        output rd_data
    );

endinterface

// File: rtl/k_edge_detect.sv
// Synchronizes one asynchronous K pin and flags a qualifying edge.
// The pin idles high, so every flop in the path resets to 1; hit is a registered
// one-clock pulse appearing SYNC_STG+1 clocks after the pin change.
module k_edge_detect #(
    parameter int unsigned SYNC_STG = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    input  logic rise_sel,   // 1: rising edge qualifies, 0: falling edge qualifies
    output logic level,      // synchronized pin level
    output logic hit
);

    logic [SYNC_STG-1:0] sync_q;
    logic                prev_q;
    logic                hit_q;
    logic                hit_d;

    // Synchronizer chain followed by the previous-level flop
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STG-2:0], pin};
            prev_q <= sync_q[SYNC_STG-1];
        end
    end

    // Polarity-qualified edge compare
    always_comb begin
        hit_d = 1'b0;
        if (rise_sel) begin
            hit_d = !prev_q && sync_q[SYNC_STG-1];
        end else begin
            hit_d = prev_q && !sync_q[SYNC_STG-1];
        end
    end

    // Register the edge pulse so the flag update is a clean single-clock event
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_q <= 1'b0;
        end else begin
            hit_q <= hit_d;
        end
    end

    assign level = sync_q[SYNC_STG-1];
    assign hit   = hit_q;

endmodule

// File: rtl/interrupt_controller.sv
// Peripheral interrupt controller: factor flags, masks and K-port edge logic in the
// 4-bit I/O space, driving level-held request lines to the microcode sequencer.
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int unsigned K0_WIDTH = 4,
    parameter int unsigned SYNC_STG = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [3:0]             timer_evt,
    input  logic [1:0]             stopwatch_evt,
    input  logic                   prog_timer_evt,
    input  logic                   serial_evt,
    input  logic [K0_WIDTH-1:0]    k0_in,
    input  logic                   k1_in,
    interrupt_controller_if.slave  bus,
    output logic [K0_WIDTH-1:0]    k0_sync,
    output logic [NUM_VECTORS-1:0] interrupt_req
);

    // Factor flags
    logic [3:0] it_q, it_d;
    logic [1:0] isw_q, isw_d;
    logic       ipt_q, ipt_d;
    logic       isio_q, isio_d;
    logic       ik0_q, ik0_d;
    logic       ik1_q, ik1_d;

    // Masks and K polarity
    logic [3:0]          eit_q;
    logic [1:0]          eisw_q;
    logic                eipt_q;
    logic                eisio_q;
    logic [K0_WIDTH-1:0] eik0_q;
    logic                eik1_q;
    logic [K0_WIDTH-1:0] kcp0_q;
    logic                kcp1_q;

    logic [3:0]             rd_data_q;
    logic [3:0]             rd_val;
    logic [NUM_VECTORS-1:0] irq_q, irq_d;

    logic [K0_WIDTH-1:0] k0_hit;
    logic                k1_hit;
    logic                k1_level_unused;

    logic clr_it, clr_isw, clr_ipt, clr_isio, clr_ik;

    for (genvar i = 0; i < K0_WIDTH; i++) begin : g_k0
        k_edge_detect #(
            .SYNC_STG (SYNC_STG)
        ) u_k0_edge (
            .clk      (clk),
            .reset_n  (reset_n),
            .pin      (k0_in[i]),
            .rise_sel (kcp0_q[i]),
            .level    (k0_sync[i]),
            .hit      (k0_hit[i])
        );
    end

    k_edge_detect #(
        .SYNC_STG (SYNC_STG)
    ) u_k1_edge (
        .clk      (clk),
        .reset_n  (reset_n),
        .pin      (k1_in),
        .rise_sel (kcp1_q),
        .level    (k1_level_unused),
        .hit      (k1_hit)
    );

    // Flag next state: read-clear first, then OR in new events so a set always wins
    always_comb begin
        clr_it   = bus.rd_en && (bus.addr == ADDR_IT);
        clr_isw  = bus.rd_en && (bus.addr == ADDR_ISW);
        clr_ipt  = bus.rd_en && (bus.addr == ADDR_IPT);
        clr_isio = bus.rd_en && (bus.addr == ADDR_ISIO);
        clr_ik   = bus.rd_en && (bus.addr == ADDR_IK);

        it_d   = (clr_it   ? 4'b0 : it_q)   | timer_evt;
        isw_d  = (clr_isw  ? 2'b0 : isw_q)  | stopwatch_evt;
        ipt_d  = (clr_ipt  ? 1'b0 : ipt_q)  | prog_timer_evt;
        isio_d = (clr_isio ? 1'b0 : isio_q) | serial_evt;
        // K edges on masked pins are dropped here rather than held
        ik0_d  = (clr_ik   ? 1'b0 : ik0_q)  | (|(k0_hit & eik0_q));
        ik1_d  = (clr_ik   ? 1'b0 : ik1_q)  | (k1_hit & eik1_q);
    end

    // Factor flag registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            it_q   <= 4'b0;
            isw_q  <= 2'b0;
            ipt_q  <= 1'b0;
            isio_q <= 1'b0;
            ik0_q  <= 1'b0;
            ik1_q  <= 1'b0;
        end else begin
            it_q   <= it_d;
            isw_q  <= isw_d;
            ipt_q  <= ipt_d;
            isio_q <= isio_d;
            ik0_q  <= ik0_d;
            ik1_q  <= ik1_d;
        end
    end

    // Mask and polarity registers; writes to flag or unused addresses are ignored
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            eit_q   <= 4'b0;
            eisw_q  <= 2'b0;
            eipt_q  <= 1'b0;
            eisio_q <= 1'b0;
            eik0_q  <= '0;
            eik1_q  <= 1'b0;
            kcp0_q  <= '0;
            kcp1_q  <= 1'b0;
        end else if (bus.wr_en) begin
            case (bus.addr)
                ADDR_EIT:   eit_q   <= bus.wr_data;
                ADDR_EISW:  eisw_q  <= bus.wr_data[1:0];
                ADDR_EIPT:  eipt_q  <= bus.wr_data[0];
                ADDR_EISIO: eisio_q <= bus.wr_data[0];
                ADDR_EIK0:  eik0_q  <= bus.wr_data[K0_WIDTH-1:0];
                ADDR_EIK1:  eik1_q  <= bus.wr_data[0];
                ADDR_KCP0:  kcp0_q  <= bus.wr_data[K0_WIDTH-1:0];
                ADDR_KCP1:  kcp1_q  <= bus.wr_data[0];
                default:    ;
            endcase
        end
    end

    // Read mux over pre-edge register values
    always_comb begin
        rd_val = 4'b0;
        case (bus.addr)
            ADDR_IT:    rd_val = it_q;
            ADDR_ISW:   rd_val = {2'b0, isw_q};
            ADDR_IPT:   rd_val = {3'b0, ipt_q};
            ADDR_ISIO:  rd_val = {3'b0, isio_q};
            ADDR_IK:    rd_val = {2'b0, ik1_q, ik0_q};
            ADDR_EIT:   rd_val = eit_q;
            ADDR_EISW:  rd_val = {2'b0, eisw_q};
            ADDR_EIPT:  rd_val = {3'b0, eipt_q};
            ADDR_EISIO: rd_val = {3'b0, eisio_q};
            ADDR_EIK0:  rd_val = 4'(eik0_q);
            ADDR_EIK1:  rd_val = {3'b0, eik1_q};
            ADDR_KCP0:  rd_val = 4'(kcp0_q);
            ADDR_KCP1:  rd_val = {3'b0, kcp1_q};
            default:    rd_val = 4'b0;
        endcase
    end

    // Registered read data, updated only on a read strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_q <= 4'b0;
        end else if (bus.rd_en) begin
            rd_data_q <= rd_val;
        end
    end

    // Request vector; K flags are already mask-qualified at set time
    always_comb begin
        irq_d                 = '0;
        irq_d[IRQ_PROG_TIMER] = |(ipt_q & eipt_q);
        irq_d[IRQ_SERIAL]     = |(isio_q & eisio_q);
        irq_d[IRQ_K0]         = ik0_q;
        irq_d[IRQ_K1]         = ik1_q;
        irq_d[IRQ_STOPWATCH]  = |(isw_q & eisw_q);
        irq_d[IRQ_CLOCK]      = |(it_q & eit_q);
    end

    // Request register, one clock behind the flags and masks
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_q <= '0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign bus.rd_data    = rd_data_q;
    assign interrupt_req  = irq_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Randomized bench for interrupt_controller with a register-file reference model.
module tb_interrupt_controller;
    import interrupt_controller_pkg::*;

    localparam int unsigned K0W  = 4;
    localparam int          S    = 2;
    localparam int          HIST = 8192;

    logic        clk;
    logic        reset_n;
    logic [3:0]  timer_evt;
    logic [1:0]  stopwatch_evt;
    logic        prog_timer_evt;
    logic        serial_evt;
    logic [3:0]  k0_in;
    logic        k1_in;
    logic [3:0]  k0_sync;
    logic [14:0] interrupt_req;

    interrupt_controller_if bus ();

    interrupt_controller #(
        .K0_WIDTH (K0W),
        .SYNC_STG (S)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .timer_evt      (timer_evt),
        .stopwatch_evt  (stopwatch_evt),
        .prog_timer_evt (prog_timer_evt),
        .serial_evt     (serial_evt),
        .k0_in          (k0_in),
        .k1_in          (k1_in),
        .bus            (bus),
        .k0_sync        (k0_sync),
        .interrupt_req  (interrupt_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Reference model: the register map as a plain 16-entry nibble file, plus pin history
    logic [3:0]  m_reg [16];
    logic [3:0]  exp_rd;
    logic [14:0] exp_req;
    logic [4:0]  pin_hist [HIST];   // {k1, k0[3:0]} sampled at each edge
    logic [4:0]  kcp_hist [HIST];   // {kcp1, kcp0[3:0]} in effect before each edge
    int          cyc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Pins idle high before reset release; polarity resets to falling edge
    function automatic logic [4:0] pin_at(input int k);
        return (k <= 0) ? 5'h1f : pin_hist[k];
    endfunction

    function automatic logic [4:0] kcp_at(input int k);
        return (k <= 0) ? 5'h00 : kcp_hist[k];
    endfunction

    function automatic logic [3:0] wmask(input logic [3:0] a);
        case (a)
            4'h8, 4'hC, 4'hE:        return 4'hF;
            4'h9:                    return 4'h3;
            4'hA, 4'hB, 4'hD, 4'hF:  return 4'h1;
            default:                 return 4'h0;
        endcase
    endfunction

    function automatic logic [14:0] req_of();
        logic [14:0] r;
        r    = '0;
        r[1] = |(m_reg[0] & m_reg[8]);
        r[2] = |(m_reg[1] & m_reg[9]);
        r[3] = m_reg[4][1];
        r[4] = m_reg[4][0];
        r[5] = |(m_reg[3] & m_reg[11]);
        r[6] = |(m_reg[2] & m_reg[10]);
        return r;
    endfunction

    function automatic int top_bit(input logic [14:0] v);
        int t;
        t = -1;
        for (int i = 0; i < 15; i++) if (v[i]) t = i;
        return t;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_reg[i] = 4'h0;
        exp_rd  = 4'h0;
        exp_req = '0;
        cyc     = 0;
    endtask

    // Advance the model across one rising edge using the currently driven inputs
    task automatic model_step();
        logic [4:0] pa, pb, pol, kev;
        logic [3:0] a;
        int n;
        cyc++;
        n = cyc;
        a = bus.addr;
        pin_hist[n] = {k1_in, k0_in};
        kcp_hist[n] = {m_reg[15][0], m_reg[14]};
        exp_req = req_of();
        if (bus.rd_en) exp_rd = m_reg[a];
        // Pin change before edge m is acted on as a flag at edge m+S+1
        pa  = pin_at(n - S - 2);
        pb  = pin_at(n - S - 1);
        pol = kcp_at(n - 1);
        for (int i = 0; i < 5; i++) kev[i] = pol[i] ? (!pa[i] && pb[i]) : (pa[i] && !pb[i]);
        if (bus.rd_en && a <= 4'h4) m_reg[a] = 4'h0;
        m_reg[0] = m_reg[0] | timer_evt;
        m_reg[1] = m_reg[1] | {2'b0, stopwatch_evt};
        m_reg[2] = m_reg[2] | {3'b0, prog_timer_evt};
        m_reg[3] = m_reg[3] | {3'b0, serial_evt};
        if (|(kev[3:0] & m_reg[12])) m_reg[4][0] = 1'b1;
        if (kev[4] && m_reg[13][0])  m_reg[4][1] = 1'b1;
        if (bus.wr_en && a >= 4'h8) m_reg[a] = bus.wr_data & wmask(a);
    endtask

    task automatic idle_strobes();
        bus.rd_en      = 1'b0;
        bus.wr_en      = 1'b0;
        timer_evt      = 4'h0;
        stopwatch_evt  = 2'h0;
        prog_timer_evt = 1'b0;
        serial_evt     = 1'b0;
    endtask

    task automatic tick();
        logic [4:0] ps;
        model_step();
        @(posedge clk);
        #1;
        ps = pin_at(cyc - S + 1);
        check_eq("rd_data", {28'h0, bus.rd_data}, {28'h0, exp_rd});
        check_eq("interrupt_req", {17'h0, interrupt_req}, {17'h0, exp_req});
        check_eq("k0_sync", {28'h0, k0_sync}, {28'h0, ps[3:0]});
        idle_strobes();
    endtask

    task automatic wr(input logic [3:0] a, input logic [3:0] d);
        bus.addr    = a;
        bus.wr_data = d;
        bus.wr_en   = 1'b1;
        tick();
    endtask

    task automatic rd(input logic [3:0] a);
        bus.addr  = a;
        bus.rd_en = 1'b1;
        tick();
    endtask

    // Asynchronous reset between edges; outputs must clear with no clock edge
    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1;
        check_eq("reset_req", {17'h0, interrupt_req}, 32'h0);
        check_eq("reset_rd_data", {28'h0, bus.rd_data}, 32'h0);
        check_eq("reset_k0_sync", {28'h0, k0_sync}, 32'hF);
        model_reset();
        #2 reset_n = 1'b1;
    endtask

    task automatic rand_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            for (int b = 0; b < 4; b++) timer_evt[b] = ($urandom_range(0, 7) == 0);
            for (int b = 0; b < 2; b++) stopwatch_evt[b] = ($urandom_range(0, 7) == 0);
            prog_timer_evt = ($urandom_range(0, 7) == 0);
            serial_evt     = ($urandom_range(0, 7) == 0);
            for (int b = 0; b < 4; b++) if ($urandom_range(0, 15) == 0) k0_in[b] = ~k0_in[b];
            if ($urandom_range(0, 15) == 0) k1_in = ~k1_in;
            bus.rd_en   = ($urandom_range(0, 3) == 0);
            bus.wr_en   = ($urandom_range(0, 2) == 0);
            bus.addr    = 4'($urandom_range(0, 15));
            bus.wr_data = 4'($urandom_range(0, 15));
            tick();
        end
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        reset_n     = 1'b1;
        k0_in       = 4'hF;
        k1_in       = 1'b1;
        bus.addr    = 4'h0;
        bus.wr_data = 4'h0;
        idle_strobes();
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Clock-timer flag, masked request, read-to-clear
        wr(ADDR_EIT, 4'h1);
        timer_evt = 4'h1;
        tick();
        check_eq("t1_req_one_clk", {17'h0, interrupt_req}, 32'h0);
        tick();
        check_eq("t1_req_set", {17'h0, interrupt_req}, 32'h0002);
        rd(ADDR_IT);
        check_eq("t1_rd_it", {28'h0, bus.rd_data}, 32'h1);
        tick();
        check_eq("t1_req_cleared", {17'h0, interrupt_req}, 32'h0);

        // Flag sets while masked; enabling the mask raises the request
        do_reset();
        timer_evt = 4'h8;
        tick();
        tick();
        check_eq("t2_req_masked", {17'h0, interrupt_req}, 32'h0);
        wr(ADDR_EIT, 4'h8);
        tick();
        check_eq("t2_req_unmasked", {17'h0, interrupt_req}, 32'h0002);

        // K0 falling edge on an enabled pin, then on a masked pin
        do_reset();
        wr(ADDR_EIK0, 4'h4);
        wr(ADDR_KCP0, 4'h0);
        k0_in = 4'b1011;
        repeat (S + 2) tick();
        check_eq("t3_req_before", {17'h0, interrupt_req}, 32'h0);
        tick();
        check_eq("t3_req_k0", {17'h0, interrupt_req}, 32'h0010);
        rd(ADDR_IK);
        check_eq("t3_rd_ik", {28'h0, bus.rd_data}, 32'h1);
        tick();
        check_eq("t3_req_cleared", {17'h0, interrupt_req}, 32'h0);
        k0_in = 4'b1001;
        repeat (S + 4) tick();
        check_eq("t3_masked_pin_req", {17'h0, interrupt_req}, 32'h0);
        rd(ADDR_IK);
        check_eq("t3_masked_pin_flag", {28'h0, bus.rd_data}, 32'h0);

        // Read-clear colliding with a new event: event wins, read shows old value
        k0_in = 4'hF;
        do_reset();
        wr(ADDR_EIPT, 4'h1);
        bus.addr       = ADDR_IPT;
        bus.rd_en      = 1'b1;
        prog_timer_evt = 1'b1;
        tick();
        check_eq("t4_rd_pre", {28'h0, bus.rd_data}, 32'h0);
        tick();
        check_eq("t4_req_pt", {17'h0, interrupt_req}, 32'h0040);
        rd(ADDR_IPT);
        check_eq("t4_rd_kept", {28'h0, bus.rd_data}, 32'h1);

        // Every source flagged and enabled
        do_reset();
        wr(ADDR_EIT, 4'hF);
        wr(ADDR_EISW, 4'h3);
        wr(ADDR_EIPT, 4'h1);
        wr(ADDR_EISIO, 4'h1);
        wr(ADDR_EIK0, 4'hF);
        wr(ADDR_EIK1, 4'h1);
        timer_evt      = 4'hF;
        stopwatch_evt  = 2'h3;
        prog_timer_evt = 1'b1;
        serial_evt     = 1'b1;
        k0_in          = 4'b1110;
        k1_in          = 1'b0;
        tick();
        repeat (S + 3) tick();
        check_eq("t5_req_all", {17'h0, interrupt_req}, 32'h007E);
        rd(ADDR_IT);
        tick();
        check_eq("t5_req_no_clock", {17'h0, interrupt_req}, 32'h007C);
        check_eq("t5_top_vector", 32'(top_bit(interrupt_req)), 32'd6);

        // Random traffic against the model
        k0_in = 4'hF;
        k1_in = 1'b1;
        do_reset();
        rand_cycles(1000);

        // Reset mid-stream with K0 held low through release
        k0_in = 4'h0;
        do_reset();
        repeat (10) tick();
        check_eq("t6_req_after_release", {17'h0, interrupt_req}, 32'h0);
        wr(ADDR_EIK0, 4'hF);
        wr(ADDR_KCP0, 4'h0);
        repeat (S + 4) tick();
        check_eq("t6_no_spurious_req", {17'h0, interrupt_req}, 32'h0);
        rd(ADDR_IK);
        check_eq("t6_no_spurious_ik0", {28'h0, bus.rd_data}, 32'h0);

        rand_cycles(1000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
